// File: rtl/spu_fwd_network_if.sv
// spu_fwd_network_if: register-file operands, in-flight pipe results and forwarded operands of the SPU forwarding network
interface spu_fwd_network_if #(
    parameter int DW   = 128,
    parameter int AW   = 7,
    parameter int NSTG = 7
);
    logic [0:31]             instr_even, instr_odd;
    logic [0:DW-1]           ra_even, rb_even, rc_even, ra_odd, rb_odd, rt_st_odd;
    logic [NSTG-1:0][0:DW-1] fw_even_wb, fw_odd_wb;
    logic [NSTG-1:0][0:AW-1] fw_addr_even_wb, fw_addr_odd_wb;
    logic [NSTG-1:0]         fw_write_even_wb, fw_write_odd_wb;
    logic [0:DW-1]           ra_even_fwd, rb_even_fwd, rc_even_fwd, ra_odd_fwd, rb_odd_fwd, rt_st_odd_fwd;
    modport master (
        output instr_even, instr_odd, ra_even, rb_even, rc_even, ra_odd, rb_odd, rt_st_odd,
               fw_even_wb, fw_odd_wb, fw_addr_even_wb, fw_addr_odd_wb, fw_write_even_wb, fw_write_odd_wb,
        input  ra_even_fwd, rb_even_fwd, rc_even_fwd, ra_odd_fwd, rb_odd_fwd, rt_st_odd_fwd
    );
    modport slave (
        input  instr_even, instr_odd, ra_even, rb_even, rc_even, ra_odd, rb_odd, rt_st_odd,
               fw_even_wb, fw_odd_wb, fw_addr_even_wb, fw_addr_odd_wb, fw_write_even_wb, fw_write_odd_wb,
        output ra_even_fwd, rb_even_fwd, rc_even_fwd, ra_odd_fwd, rb_odd_fwd, rt_st_odd_fwd
    );
endinterface

// File: rtl/spu_fwd_network.sv
// spu_fwd_network: SPU even/odd operand forwarding; SPU_FWD_HIT_CNT_EN adds a registered 32-bit hit counter
module spu_fwd_network #(
    parameter int DW   = 128,
    parameter int AW   = 7,
    parameter int NSTG = 7
) (
    input  logic               clk,
    input  logic               reset,
    spu_fwd_network_if.slave   io
`ifdef SPU_FWD_HIT_CNT_EN
    ,
    output logic [31:0]        fwd_hit_count
`endif
);
    logic [0:AW-1] addr [6];
    logic [0:DW-1] rf   [6];
    logic [0:DW-1] fwd  [6];
    logic [5:0]    hit;
    logic [21:0]   unused_instr;
    assign addr[0] = io.instr_even[18:24];
    assign addr[1] = io.instr_even[11:17];
    assign addr[2] = io.instr_even[25:31];
    assign addr[3] = io.instr_odd[18:24];
    assign addr[4] = io.instr_odd[11:17];
    assign addr[5] = io.instr_odd[25:31];
    assign rf[0] = io.ra_even;
    assign rf[1] = io.rb_even;
    assign rf[2] = io.rc_even;
    assign rf[3] = io.ra_odd;
    assign rf[4] = io.rb_odd;
    assign rf[5] = io.rt_st_odd;
    assign unused_instr = {io.instr_even[0:10], io.instr_odd[0:10]};
    // Scan oldest to youngest, even before odd, so the last match written is the highest priority.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            fwd[k] = rf[k];
            hit[k] = 1'b0;
            for (int i = NSTG - 1; i >= 0; i--) begin
                if (io.fw_write_even_wb[i] && io.fw_addr_even_wb[i] == addr[k]) begin
                    fwd[k] = io.fw_even_wb[i];
                    hit[k] = 1'b1;
                end
                if (io.fw_write_odd_wb[i] && io.fw_addr_odd_wb[i] == addr[k]) begin
                    fwd[k] = io.fw_odd_wb[i];
                    hit[k] = 1'b1;
                end
            end
            if (reset) begin
                fwd[k] = rf[k];
                hit[k] = 1'b0;
            end
        end
    end
    assign io.ra_even_fwd   = fwd[0];
    assign io.rb_even_fwd   = fwd[1];
    assign io.rc_even_fwd   = fwd[2];
    assign io.ra_odd_fwd    = fwd[3];
    assign io.rb_odd_fwd    = fwd[4];
    assign io.rt_st_odd_fwd = fwd[5];
`ifdef SPU_FWD_HIT_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  n_hit;
    always_comb begin
        n_hit = '0;
        for (int k = 0; k < 6; k++) n_hit = n_hit + 3'(hit[k]);
        cnt_d = reset ? '0 : cnt_q + 32'(n_hit);
    end
    always_ff @(posedge clk) cnt_q <= cnt_d;
    assign fwd_hit_count = cnt_q;
`else
    logic [6:0] unused_sig;
    assign unused_sig = {clk, hit};
`endif
endmodule

// File: tb/tb_spu_fwd_network.sv
// tb_spu_fwd_network: directed and randomized checks of spu_fwd_network against a first-match reference model
module tb_spu_fwd_network;
    localparam int NSTG = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    spu_fwd_network_if bus ();
`ifdef SPU_FWD_HIT_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] exp_cnt = '0;
`endif
    spu_fwd_network dut (
        .clk   (clk),
        .reset (rst),
        .io    (bus)
`ifdef SPU_FWD_HIT_CNT_EN
        ,
        .fwd_hit_count (hit_cnt)
`endif
    );
    logic [0:31]  instr_e, instr_o;
    logic [0:127] rfv [6];
    logic [0:127] fwv_e [NSTG];
    logic [0:127] fwv_o [NSTG];
    logic [0:6]   fwa_e [NSTG];
    logic [0:6]   fwa_o [NSTG];
    logic         fww_e [NSTG];
    logic         fww_o [NSTG];
    int n_cmp = 0;
    int n_err = 0;
    task automatic chk(input string tag, input logic [0:127] got, input logic [0:127] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [0:6] op_addr(input int k);
        case (k)
            0: return instr_e[18:24];
            1: return instr_e[11:17];
            2: return instr_e[25:31];
            3: return instr_o[18:24];
            4: return instr_o[11:17];
            default: return instr_o[25:31];
        endcase
    endfunction
    // Candidates in program-order priority: youngest stage first, odd before even within a stage.
    function automatic logic [0:127] ref_fwd(input int k, output bit h);
        logic [0:6] a = op_addr(k);
        h = 1'b0;
        if (rst) return rfv[k];
        for (int s = 0; s < NSTG; s++) begin
            if (fww_o[s] === 1'b1 && fwa_o[s] == a) begin h = 1'b1; return fwv_o[s]; end
            if (fww_e[s] === 1'b1 && fwa_e[s] == a) begin h = 1'b1; return fwv_e[s]; end
        end
        return rfv[k];
    endfunction
    function automatic int model_hits();
        int n = 0;
        bit h;
        logic [0:127] v;
        for (int k = 0; k < 6; k++) begin
            v = ref_fwd(k, h);
            n += int'(h);
        end
        return n;
    endfunction
    function automatic logic [0:127] dut_out(input int k);
        case (k)
            0: return bus.ra_even_fwd;
            1: return bus.rb_even_fwd;
            2: return bus.rc_even_fwd;
            3: return bus.ra_odd_fwd;
            4: return bus.rb_odd_fwd;
            default: return bus.rt_st_odd_fwd;
        endcase
    endfunction
    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic clear();
        instr_e = '0;
        instr_o = '0;
        for (int k = 0; k < 6; k++) rfv[k] = rnd128();
        for (int s = 0; s < NSTG; s++) begin
            fww_e[s] = 1'b0; fww_o[s] = 1'b0;
            fwa_e[s] = 7'($urandom); fwa_o[s] = 7'($urandom);
            fwv_e[s] = 'x; fwv_o[s] = 'x;
        end
    endtask
    task automatic drive();
        bus.instr_even = instr_e;
        bus.instr_odd  = instr_o;
        bus.ra_even = rfv[0]; bus.rb_even = rfv[1]; bus.rc_even = rfv[2];
        bus.ra_odd  = rfv[3]; bus.rb_odd  = rfv[4]; bus.rt_st_odd = rfv[5];
        for (int s = 0; s < NSTG; s++) begin
            bus.fw_even_wb[s] = fwv_e[s]; bus.fw_addr_even_wb[s] = fwa_e[s]; bus.fw_write_even_wb[s] = fww_e[s];
            bus.fw_odd_wb[s]  = fwv_o[s]; bus.fw_addr_odd_wb[s]  = fwa_o[s]; bus.fw_write_odd_wb[s]  = fww_o[s];
        end
    endtask
    task automatic check_all(input string tag);
        bit h;
        for (int k = 0; k < 6; k++) chk($sformatf("%s_op%0d", tag, k), dut_out(k), ref_fwd(k, h));
    endtask
`ifdef SPU_FWD_HIT_CNT_EN
    always @(posedge clk) exp_cnt <= rst ? 32'd0 : exp_cnt + 32'(model_hits());
`endif
    initial begin
        clear();
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rfv[0] = {16{8'hAA}};
        drive();
        #1;
        chk("t1_ra_even", bus.ra_even_fwd, {16{8'hAA}});
        check_all("t1");
        @(negedge clk);
        clear();
        instr_e[18:24] = 7'd5;
        fww_e[3] = 1'b1; fwa_e[3] = 7'd5; fwv_e[3] = 128'h1234;
        drive();
        #1;
        chk("t2_ra_even", bus.ra_even_fwd, 128'h1234);
        chk("t2_rb_even", bus.rb_even_fwd, rfv[1]);
        check_all("t2");
        @(negedge clk);
        clear();
        instr_o[18:24] = 7'd9;
        fww_e[2] = 1'b1; fwa_e[2] = 7'd9; fwv_e[2] = 128'h22;
        fww_o[4] = 1'b1; fwa_o[4] = 7'd9; fwv_o[4] = 128'h44;
        drive();
        #1;
        chk("t3_ra_odd", bus.ra_odd_fwd, 128'h22);
        check_all("t3");
        @(negedge clk);
        clear();
        instr_e[11:17] = 7'd7;
        fww_e[1] = 1'b1; fwa_e[1] = 7'd7; fwv_e[1] = 128'h70;
        fww_o[1] = 1'b1; fwa_o[1] = 7'd7; fwv_o[1] = 128'h71;
        drive();
        #1;
        chk("t4_rb_even", bus.rb_even_fwd, 128'h71);
        check_all("t4");
        @(negedge clk);
        clear();
        instr_e[25:31] = 7'd12;
        fwa_e[0] = 7'd12;
        drive();
        #1;
        chk("t5_rc_even", bus.rc_even_fwd, rfv[2]);
        check_all("t5");
        @(negedge clk);
        clear();
        instr_e[11:17] = 7'd7;
        fww_o[0] = 1'b1; fwa_o[0] = 7'd7; fwv_o[0] = 128'h71;
        rst = 1'b1;
        drive();
        #1;
        chk("t6_rb_even_rst", bus.rb_even_fwd, rfv[1]);
        check_all("t6");
`ifdef SPU_FWD_HIT_CNT_EN
        @(negedge clk);
        chk("t6_cnt_rst", 128'(hit_cnt), 128'd0);
        clear();
        instr_e[18:24] = 7'd1; instr_e[11:17] = 7'd2; instr_e[25:31] = 7'd3;
        instr_o[18:24] = 7'd100; instr_o[11:17] = 7'd100; instr_o[25:31] = 7'd100;
        fww_e[0] = 1'b1; fwa_e[0] = 7'd1; fwv_e[0] = rnd128();
        fww_e[1] = 1'b1; fwa_e[1] = 7'd2; fwv_e[1] = rnd128();
        fww_o[2] = 1'b1; fwa_o[2] = 7'd3; fwv_o[2] = rnd128();
        rst = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        chk("t6_cnt_six", 128'(hit_cnt), 128'd6);
`endif
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 19) == 0);
            instr_e = $urandom;
            instr_o = $urandom;
            instr_e[18:24] = 7'($urandom_range(0, 7)); instr_e[11:17] = 7'($urandom_range(0, 7));
            instr_e[25:31] = 7'($urandom_range(0, 7)); instr_o[18:24] = 7'($urandom_range(0, 7));
            instr_o[11:17] = 7'($urandom_range(0, 7)); instr_o[25:31] = 7'($urandom_range(0, 7));
            for (int k = 0; k < 6; k++) rfv[k] = rnd128();
            for (int s = 0; s < NSTG; s++) begin
                fww_e[s] = ($urandom_range(0, 3) == 0); fwa_e[s] = 7'($urandom_range(0, 7));
                fwv_e[s] = fww_e[s] ? rnd128() : 'x;
                fww_o[s] = ($urandom_range(0, 3) == 0); fwa_o[s] = 7'($urandom_range(0, 7));
                fwv_o[s] = fww_o[s] ? rnd128() : 'x;
            end
            drive();
            #1;
            check_all($sformatf("rnd%0d", it));
`ifdef SPU_FWD_HIT_CNT_EN
            chk($sformatf("rnd%0d_cnt", it), 128'(hit_cnt), 128'(exp_cnt));
`endif
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
